// File: rtl/ekf_stage_sched.sv
// ekf_stage_sched: turns odometry events and landmark observations into
// one-hot PRD/NEW/UPD stage requests, one outstanding stage at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | pick next stage: pending odometry first, then FIFO head
// ISSUE     | stage chosen, waiting for controller READY to send it
// WAIT_BUSY | request sent, waiting for controller to leave READY
// WAIT_DONE | controller busy, waiting for READY to close the stage
module ekf_stage_sched #(
  parameter int ROW_LEN      = 10,
  parameter int MAX_LANDMARK = 500,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               odom_val,
  output logic               odom_rdy,
  input  logic               obs_val,
  output logic               obs_rdy,
  input  logic [ROW_LEN-1:0] obs_id,
  input  logic [2:0]         stage_rdy,
  output logic [2:0]         stage_val,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] lm_id,
  output logic               sched_busy,
  output logic               stage_done,
  output logic               obs_drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]        DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [ROW_LEN-1:0] MAX_LM   = ROW_LEN'(MAX_LANDMARK);
  localparam logic [2:0]         CODE_PRD = 3'b001;
  localparam logic [2:0]         CODE_NEW = 3'b010;
  localparam logic [2:0]         CODE_UPD = 3'b100;
  localparam logic [2:0]         RDY_ALL  = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_nxt;

  logic [ROW_LEN-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               fifo_empty;
  logic [ROW_LEN-1:0] head;
  logic               push, pop;

  logic               odom_pend;
  logic [2:0]         cur_code;

  logic               load_sel;
  logic [2:0]         sel_code;
  logic [ROW_LEN-1:0] sel_id;
  logic               drop;
  logic               issue_fire;
  logic               done_fire;

  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign obs_rdy    = (count != DEPTH_C);
  assign push       = obs_val & obs_rdy;
  assign odom_rdy   = !odom_pend;
  assign sched_busy = (state != IDLE);

  // Next-state decode and the strobes that drive the register updates.
  always_comb begin
    state_nxt  = state;
    load_sel   = 1'b0;
    sel_code   = 3'b000;
    sel_id     = '0;
    pop        = 1'b0;
    drop       = 1'b0;
    issue_fire = 1'b0;
    done_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (odom_pend) begin
          load_sel  = 1'b1;
          sel_code  = CODE_PRD;
          state_nxt = ISSUE;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (head < landmark_num) begin
            load_sel  = 1'b1;
            sel_code  = CODE_UPD;
            sel_id    = head;
            state_nxt = ISSUE;
          end else if ((head == landmark_num) && (landmark_num < MAX_LM)) begin
            load_sel  = 1'b1;
            sel_code  = CODE_NEW;
            sel_id    = head;
            state_nxt = ISSUE;
          end else begin
            // Unknown id or table full: discard the observation.
            drop = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (stage_rdy == RDY_ALL) begin
          issue_fire = 1'b1;
          state_nxt  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (stage_rdy != RDY_ALL) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (stage_rdy == RDY_ALL) begin
          done_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, registered outputs, odometry flag and landmark count.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      stage_val    <= 3'b000;
      stage_done   <= 1'b0;
      obs_drop     <= 1'b0;
      lm_id        <= '0;
      cur_code     <= 3'b000;
      odom_pend    <= 1'b0;
      landmark_num <= '0;
    end else begin
      state      <= state_nxt;
      stage_val  <= issue_fire ? cur_code : 3'b000;
      stage_done <= done_fire;
      obs_drop   <= drop;
      if (load_sel) begin
        cur_code <= sel_code;
        lm_id    <= sel_id;
      end
      if (issue_fire && (cur_code == CODE_PRD)) odom_pend <= 1'b0;
      else if (odom_val && !odom_pend)          odom_pend <= 1'b1;
      // Count only grows on a completed NEW; it saturates rather than wraps.
      if (done_fire && (cur_code == CODE_NEW) && (landmark_num < MAX_LM))
        landmark_num <= landmark_num + ROW_LEN'(1);
    end
  end

  // Observation FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  // Observation storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= obs_id;
  end

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Bench for ekf_stage_sched: directed stimulus, scoreboard of expected
// stage/done/drop events, and a simple controller model on stage_rdy.
module tb_ekf_stage_sched;

  localparam int ROW_LEN = 10;
  localparam int MAX_LM  = 6;

  logic               clk = 1'b0;
  logic               sys_rst;
  logic               odom_val;
  logic               odom_rdy;
  logic               obs_val;
  logic               obs_rdy;
  logic [ROW_LEN-1:0] obs_id;
  logic [2:0]         stage_rdy;
  logic [2:0]         stage_val;
  logic [ROW_LEN-1:0] landmark_num;
  logic [ROW_LEN-1:0] lm_id;
  logic               sched_busy;
  logic               stage_done;
  logic               obs_drop;

  ekf_stage_sched #(.ROW_LEN(ROW_LEN), .MAX_LANDMARK(MAX_LM), .FIFO_DEPTH(4)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .odom_val(odom_val), .odom_rdy(odom_rdy),
    .obs_val(obs_val), .obs_rdy(obs_rdy), .obs_id(obs_id),
    .stage_rdy(stage_rdy), .stage_val(stage_val),
    .landmark_num(landmark_num), .lm_id(lm_id),
    .sched_busy(sched_busy), .stage_done(stage_done), .obs_drop(obs_drop)
  );

  always #5 clk = ~clk;

  localparam int K_STAGE = 0, K_DONE = 1, K_DROP = 2;
  typedef struct {
    int kind;
    int code;
    int val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   busy_len = 5;
  bit   ctrl_abort = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_ev(input int kind, input int code, input int val);
    exp_t e;
    e.kind = kind; e.code = code; e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_event(input int kind, input int code, input int val);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL event: unexpected kind=%0d code=%0d val=%0d", kind, code, val);
    end else begin
      e = sb.pop_front();
      if (e.kind == kind && e.code == code && e.val == val) n_pass++;
      else $display("FAIL event: got kind=%0d code=%0d val=%0d expected kind=%0d code=%0d val=%0d",
                    kind, code, val, e.kind, e.code, e.val);
    end
  endtask

  // Monitor: every DUT event is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (stage_val != 3'b000) check_event(K_STAGE, int'(stage_val), int'(lm_id));
    if (stage_done)          check_event(K_DONE, 0, int'(landmark_num));
    if (obs_drop)            check_event(K_DROP, 0, 0);
  end

  // Controller model: on a request go BUSY for busy_len cycles, then READY.
  initial begin
    stage_rdy = 3'b111;
    forever begin
      @(negedge clk);
      if (stage_val != 3'b000) begin
        stage_rdy = 3'b000;
        for (int i = 0; i < busy_len && !ctrl_abort; i++) @(negedge clk);
        stage_rdy = 3'b111;
      end
    end
  end

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (sb.size() == 0 && !sched_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) chk({name, " idle timeout"}, sb.size(), 0);
  endtask

  task automatic wait_stage(input string name);
    int n = 0;
    while (stage_val == 3'b000 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (stage_val == 3'b000) chk({name, " stage timeout"}, 0, 1);
  endtask

  task automatic pulse_odom();
    odom_val = 1'b1;
    @(negedge clk);
    odom_val = 1'b0;
  endtask

  // Hold obs_val until the beat is accepted; reports obs_rdy at first try.
  task automatic push_obs(input int id, output bit first_rdy);
    bit acc;
    int n = 0;
    obs_val = 1'b1;
    obs_id  = ROW_LEN'(id);
    first_rdy = obs_rdy;
    acc = 1'b0;
    while (!acc && n < 500) begin
      acc = obs_rdy;
      @(negedge clk);
      n++;
    end
    obs_val = 1'b0;
    if (!acc) chk("push timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " stage_val"},    int'(stage_val), 0);
    chk({tag, " stage_done"},   int'(stage_done), 0);
    chk({tag, " obs_drop"},     int'(obs_drop), 0);
    chk({tag, " landmark_num"}, int'(landmark_num), 0);
    chk({tag, " lm_id"},        int'(lm_id), 0);
    chk({tag, " sched_busy"},   int'(sched_busy), 0);
    chk({tag, " odom_rdy"},     int'(odom_rdy), 1);
    chk({tag, " obs_rdy"},      int'(obs_rdy), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    bit fifth_rdy;
    sys_rst = 1'b1; odom_val = 1'b0; obs_val = 1'b0; obs_id = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    @(negedge clk);

    // Single PRD with 5 busy cycles.
    busy_len = 5;
    expect_ev(K_STAGE, 1, 0); expect_ev(K_DONE, 0, 0);
    pulse_odom();
    chk("odom_rdy after accept", int'(odom_rdy), 0);
    wait_idle("prd");
    chk("odom_rdy after prd", int'(odom_rdy), 1);

    // ids 0,0,1 -> NEW 0, UPD 0, NEW 1.
    busy_len = 2;
    expect_ev(K_STAGE, 2, 0); expect_ev(K_DONE, 0, 1);
    expect_ev(K_STAGE, 4, 0); expect_ev(K_DONE, 0, 1);
    expect_ev(K_STAGE, 2, 1); expect_ev(K_DONE, 0, 2);
    push_obs(0, r); push_obs(0, r); push_obs(1, r);
    wait_idle("new_upd");
    chk("landmark_num after new/upd", int'(landmark_num), 2);

    // Unknown id is dropped.
    expect_ev(K_DROP, 0, 0);
    push_obs(5, r);
    wait_idle("drop");
    chk("landmark_num after drop", int'(landmark_num), 2);
    chk("obs_rdy after drop", int'(obs_rdy), 1);

    // Odometry and observation in the same cycle: PRD first.
    expect_ev(K_STAGE, 1, 0); expect_ev(K_DONE, 0, 2);
    expect_ev(K_STAGE, 2, 2); expect_ev(K_DONE, 0, 3);
    odom_val = 1'b1; obs_val = 1'b1; obs_id = ROW_LEN'(2);
    @(negedge clk);
    odom_val = 1'b0; obs_val = 1'b0;
    wait_idle("prd_first");

    // FIFO fill while a long stage is busy.
    busy_len = 20;
    expect_ev(K_STAGE, 1, 0); expect_ev(K_DONE, 0, 3);
    expect_ev(K_STAGE, 2, 3); expect_ev(K_DONE, 0, 4);
    expect_ev(K_STAGE, 4, 0); expect_ev(K_DONE, 0, 4);
    expect_ev(K_STAGE, 4, 1); expect_ev(K_DONE, 0, 4);
    expect_ev(K_STAGE, 2, 4); expect_ev(K_DONE, 0, 5);
    expect_ev(K_STAGE, 4, 2); expect_ev(K_DONE, 0, 5);
    pulse_odom();
    wait_stage("fill");
    push_obs(3, r); push_obs(0, r); push_obs(1, r); push_obs(4, r);
    chk("obs_rdy low when full", int'(obs_rdy), 0);
    push_obs(2, fifth_rdy);
    chk("fifth push first obs_rdy", int'(fifth_rdy), 0);
    busy_len = 2;
    wait_idle("fill");
    chk("landmark_num after fill", int'(landmark_num), 5);

    // Saturation at MAX_LANDMARK: last NEW, then equal id is dropped.
    expect_ev(K_STAGE, 2, 5); expect_ev(K_DONE, 0, 6);
    expect_ev(K_DROP, 0, 0);
    push_obs(5, r); push_obs(6, r);
    wait_idle("sat");
    chk("landmark_num saturated", int'(landmark_num), MAX_LM);

    // Reset during WAIT_DONE abandons the stage.
    busy_len = 1000;
    expect_ev(K_STAGE, 4, 4);
    push_obs(4, r);
    wait_stage("rst");
    repeat (3) @(negedge clk);
    chk("in stage before reset", int'(sched_busy), 1);
    sys_rst = 1'b1;
    ctrl_abort = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid reset");
    sys_rst = 1'b0;
    repeat (5) @(negedge clk);
    ctrl_abort = 1'b0;
    busy_len = 2;
    repeat (10) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    chk("idle after reset", int'(sched_busy), 0);
    chk("landmark_num after reset", int'(landmark_num), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
